// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - per-thread load/store unit
//
// Converts the operands latched by the thread register file (rs = address,
// rt = store data) into one valid/ready transaction on the memory controller
// read or write channel. Load data is returned on lsu_out for writeback and
// progress is reported to the scheduler on lsu_state. A watchdog aborts a
// request the controller never acknowledges so the core cannot hang.
//
// Ports:
//   clk, reset (async, active-low), enable (thread active; low freezes all)
//   core_state                 scheduler state (REQUEST=3'b011, UPDATE=3'b110)
//   decoded_mem_read_enable    instruction is a load
//   decoded_mem_write_enable   instruction is a store
//   rs, rt                     address operand / store-data operand
//   mem_read_*                 read channel (valid/address out, ready/data in)
//   mem_write_*                write channel (valid/address/data out, ready in)
//   lsu_state                  IDLE=0, REQUESTING=1, WAITING=2, DONE=3
//   lsu_out                    last load result (all ones after a load timeout)
//   lsu_error                  sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module lsu #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [7:0]           rs,
   input  logic [7:0]           rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_REQUESTING = 2'd1;
   localparam logic [1:0] S_WAITING    = 2'd2;
   localparam logic [1:0] S_DONE       = 2'd3;

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   // Last counter value before the watchdog fires; valid is then high for
   // exactly TIMEOUT_CYCLES cycles.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]           state_q,    state_d;
   logic                 is_read_q,  is_read_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 wr_valid_q, wr_valid_d;
   logic [ADDR_BITS-1:0] rd_addr_q,  rd_addr_d;
   logic [ADDR_BITS-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_BITS-1:0] wr_data_q,  wr_data_d;
   logic [DATA_BITS-1:0] out_q,      out_d;
   logic                 err_q,      err_d;
   logic [7:0]           count_q,    count_d;
   logic                 ready_s;

   // Only the ready of the channel owning the transaction counts.
   always_comb begin
      if (is_read_q) begin
         ready_s = mem_read_ready;
      end else begin
         ready_s = mem_write_ready;
      end
   end

   // Next-state and datapath update for the transaction FSM.
   always_comb begin
      state_d    = state_q;
      is_read_d  = is_read_q;
      rd_valid_d = rd_valid_q;
      wr_valid_d = wr_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_d      = out_q;
      err_d      = err_q;
      count_d    = count_q;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if ((core_state == CORE_REQUEST) &&
                   (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                  // Read wins when both enables are high.
                  is_read_d = decoded_mem_read_enable;
                  state_d   = S_REQUESTING;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_REQUESTING: begin
               // rs/rt are stable now; capture them and launch the request.
               if (is_read_q) begin
                  rd_addr_d  = rs[ADDR_BITS-1:0];
                  rd_valid_d = 1'b1;
               end else begin
                  wr_addr_d  = rs[ADDR_BITS-1:0];
                  wr_data_d  = rt[DATA_BITS-1:0];
                  wr_valid_d = 1'b1;
               end
               count_d = 8'd0;
               state_d = S_WAITING;
            end
            S_WAITING: begin
               if (ready_s) begin
                  // Ready takes priority over a watchdog expiring this cycle.
                  rd_valid_d = 1'b0;
                  wr_valid_d = 1'b0;
                  if (is_read_q) begin
                     out_d = mem_read_data;
                  end else begin
                     out_d = out_q;
                  end
                  state_d = S_DONE;
               end else if (count_q == TIMEOUT_LAST) begin
                  rd_valid_d = 1'b0;
                  wr_valid_d = 1'b0;
                  err_d      = 1'b1;
                  if (is_read_q) begin
                     out_d = {DATA_BITS{1'b1}};
                  end else begin
                     out_d = out_q;
                  end
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + 8'd1;
               end
            end
            S_DONE: begin
               if (core_state == CORE_UPDATE) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d    = S_IDLE;
               rd_valid_d = 1'b0;
               wr_valid_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         is_read_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= {ADDR_BITS{1'b0}};
         wr_addr_q  <= {ADDR_BITS{1'b0}};
         wr_data_q  <= {DATA_BITS{1'b0}};
         out_q      <= {DATA_BITS{1'b0}};
         err_q      <= 1'b0;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         is_read_q  <= is_read_d;
         rd_valid_q <= rd_valid_d;
         wr_valid_q <= wr_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         out_q      <= out_d;
         err_q      <= err_d;
         count_q    <= count_d;
      end
   end

   assign mem_read_valid    = rd_valid_q;
   assign mem_read_address  = rd_addr_q;
   assign mem_write_valid   = wr_valid_q;
   assign mem_write_address = wr_addr_q;
   assign mem_write_data    = wr_data_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;

endmodule

// File: doc/lsu.md
# lsu

Per-thread load/store unit that turns the operands latched by the thread's register file (rs = address, rt = store data) into a valid/ready transaction on the memory controller port. It returns load data as `lsu_out` for register writeback, and reports its progress to the core scheduler via `lsu_state`. A watchdog aborts any transaction the controller never acknowledges so the core cannot hang.

## Interface
- `ADDR_BITS`, 8: memory address width; address is taken from `rs[ADDR_BITS-1:0]`.
- `DATA_BITS`, 8: memory data width.
- `TIMEOUT_CYCLES`, 255: maximum cycles a request stays valid without ready. Legal range 1..255.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `enable` in 1: thread active; when low, all state and outputs hold.
- `core_state` in 3: scheduler state (REQUEST=3'b011, UPDATE=3'b110).
- `decoded_mem_read_enable` in 1: instruction is LDR.
- `decoded_mem_write_enable` in 1: instruction is STR.
- `rs` in 8: latched operand A, used as the address.
- `rt` in 8: latched operand B, used as the store data.
- `mem_read_valid` out 1 / `mem_read_address` out ADDR_BITS / `mem_read_ready` in 1 / `mem_read_data` in DATA_BITS: read channel.
- `mem_write_valid` out 1 / `mem_write_address` out ADDR_BITS / `mem_write_data` out DATA_BITS / `mem_write_ready` in 1: write channel.
- `lsu_state` out 2: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
- `lsu_out` out DATA_BITS: load result, held until the next load completes.
- `lsu_error` out 1: sticky timeout flag.

## Operation
- Reset value of all outputs is 0; `lsu_state` resets to IDLE; the watchdog counter resets to 0.
- IDLE:
  - Goes to REQUESTING when `core_state`==REQUEST and either mem enable is high.
  - The operation is captured as read or write at this transition. Read wins if both enables are high.
  - With neither enable high, stays in IDLE.
- REQUESTING:
  - Lasts one cycle so that rs/rt, which the register file latches during REQUEST, are stable.
  - On exit, registers address = `rs[ADDR_BITS-1:0]`. For a write, also registers data = `rt[DATA_BITS-1:0]`.
  - Sets the selected valid to 1, clears the watchdog counter, and goes to WAITING.
- WAITING:
  - Valid, address and data hold constant.
  - Ready sampled high:
    - Clears valid.
    - For a read, registers `lsu_out` = `mem_read_data`.
    - Goes to DONE.
  - Ready low with counter == TIMEOUT_CYCLES-1:
    - Clears valid and sets `lsu_error`=1.
    - For a read, sets `lsu_out`={DATA_BITS{1'b1}}.
    - Goes to DONE.
  - Ready low otherwise: counter increments.
- DONE: holds until `core_state`==UPDATE, then goes to IDLE (writeback occurs in that UPDATE cycle).
- Ready on the inactive channel is ignored.
- Addresses and data are never altered arithmetically; upper operand bits beyond ADDR_BITS are truncated.
- `lsu_error` clears only on reset.
- `enable` low freezes the FSM, counter and outputs. A held valid stays asserted.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Edge E0 ends the REQUEST cycle: state becomes REQUESTING.
- E1: state becomes WAITING; valid/address/data become visible.
- Ready high in the first WAITING cycle: at E2, state=DONE, valid=0, `lsu_out` updated. Minimum latency is 3 edges.
- Ready arriving k cycles after valid rises: DONE at edge E2+k.
- Timeout: valid is high for exactly TIMEOUT_CYCLES cycles, then drops; DONE follows on the same edge.
- Ready and timeout in the same cycle: ready wins, no error.
- `reset` asserted mid-transaction: valid drops asynchronously and state returns to IDLE. The controller must tolerate an abandoned request.
- REQUEST while in REQUESTING, WAITING or DONE: ignored.

## Test plan
- Load, ready in the first WAITING cycle:
  - Stimulus: rs=0x2A, `mem_read_data`=0x5C.
  - Response: `mem_read_address`=0x2A visible after E1; at E2, `lsu_out`=0x5C, state=DONE. UPDATE then returns state to IDLE.
- Store with 4-cycle ready delay:
  - Stimulus: rs=0x10, rt=0x99.
  - Response: valid high 5 cycles with address 0x10 and data 0x99; `mem_read_valid` stays 0; `lsu_out` unchanged.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load, ready never asserted.
  - Response: valid high exactly 4 cycles; then `lsu_error`=1, `lsu_out`=0xFF, state=DONE. Error persists across the next successful load.
- Both enables high:
  - Response: only `mem_read_valid` asserts.
  - Follow-up: a later UPDATE without a prior REQUEST leaves IDLE unchanged.
- Enable low in WAITING for 3 cycles with ready high:
  - Response: no completion and valid held; completes on the first enabled cycle.
- Async reset mid-WAITING:
  - Stimulus: `reset`=0 between edges.
  - Response: valid=0 and state=IDLE immediately. After release, a fresh load completes normally.
